usart_frame_arb: RTL and testbench



---
 rtl/usart_frame_arb.sv | 157 +++++++++++++++
 tb/tb_usart_frame_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_frame_arb.sv
// Shares one 5-byte USART report transmitter between NREQ requesters, holding the granted payload for a full frame.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module usart_frame_arb #(
  parameter int NREQ      = 4,
  parameter int BPS_CNT   = 434,
  parameter int FRAME_CYC = 5*(10*BPS_CNT+1)+16,
  parameter int TRIG_HI   = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    req_adr_i,
  input  logic [6*NREQ-1:0]    req_mod_i,
  input  logic [24*NREQ-1:0]   req_data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 trig_o,
  output logic [1:0]           Adress_o,
  output logic [5:0]           Mod_SEL_o,
  output logic [23:0]          D_o,
  output logic                 busy_o,
  output logic [2:0]           grant_id_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] TRIG = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;
  localparam int CNT_W = $clog2(FRAME_CYC + TRIG_HI + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic [1:0]       adr_q, adr_d;
  logic [5:0]       mod_q, mod_d;
  logic [23:0]      data_q, data_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       winner;

  function automatic logic [2:0] lowestSet(input logic [NREQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  assign winner = lowestSet(req_i);
`else
  logic [2:0]      rrPtr_q, rrPtr_d;
  logic [NREQ-1:0] aboveMask;
  logic [NREQ-1:0] reqAbove;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  assign aboveMask = ~((NREQ'(1) << rrPtr_q) - NREQ'(1));
  assign reqAbove  = req_i & aboveMask;
  assign winner    = (reqAbove != '0) ? lowestSet(reqAbove) : lowestSet(req_i);
  assign rrPtr_d   = (state_q == IDLE && req_i != '0)
                     ? ((winner == 3'(NREQ-1)) ? 3'd0 : winner + 3'd1)
                     : rrPtr_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) rrPtr_q <= '0;
    else          rrPtr_q <= rrPtr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    trig_d  = trig_q;
    busy_d  = busy_q;
    adr_d   = adr_q;
    mod_d   = mod_q;
    data_d  = data_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          grant_d = winner;
          cnt_d   = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (winner == 3'(i)) begin
              ack_d[i] = 1'b1;
              adr_d    = req_adr_i[2*i +: 2];
              mod_d    = req_mod_i[6*i +: 6];
              data_d   = req_data_i[24*i +: 24];
            end
          end
        end
      end
      LOAD: begin
        state_d = TRIG;
        trig_d  = 1'b1;
      end
      TRIG: begin
        if (cnt_q == CNT_W'(TRIG_HI-1)) begin
          state_d = WAIT;
          trig_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        // The transmitter has no done flag, so the frame time is simply counted out.
        if (cnt_q == CNT_W'(FRAME_CYC-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      adr_q   <= '0;
      mod_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      adr_q   <= adr_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign ack_o      = ack_q;
  assign trig_o     = trig_q;
  assign busy_o     = busy_q;
  assign Adress_o   = adr_q;
  assign Mod_SEL_o  = mod_q;
  assign D_o        = data_q;
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_usart_frame_arb.sv
// Bench for usart_frame_arb: a frame-timeline reference model checked every cycle plus directed grant-order scenarios.
module tb_usart_frame_arb;

  localparam int NREQ      = 4;
  localparam int BPS_CNT   = 4;
  localparam int FRAME_CYC = 221;
  localparam int TRIG_HI   = 2;
  localparam int BUSY_LEN  = 1 + TRIG_HI + FRAME_CYC;
  localparam int PERIOD    = BUSY_LEN + 1;

  logic                sysClk = 1'b0;
  logic                sysRst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [2*NREQ-1:0]   reqAdr = '0;
  logic [6*NREQ-1:0]   reqMod = '0;
  logic [24*NREQ-1:0]  reqData = '0;
  logic [NREQ-1:0]     ack;
  logic                trig;
  logic [1:0]          adress;
  logic [5:0]          modSel;
  logic [23:0]         dOut;
  logic                busy;
  logic [2:0]          grantId;

  int errors = 0;
  int checks = 0;

  // Model: the arbiter samples req at nextSample; a grant at edge E makes outputs busy for edges E..E+BUSY_LEN-1.
  int         edgeNo = 0;
  int         frameStart = -100000;
  int         nextSample = 1;
  int         rrPtr = 0;
  logic [2:0] mGrant = '0;
  logic [1:0] mAdr = '0;
  logic [5:0] mMod = '0;
  logic [23:0] mData = '0;
  bit         dropOnAck [NREQ];
  bit         jitter = 1'b0;
  logic       prevTrig = 1'b0;
  int         obsGrants [$];
  int         trigEdges [$];

  always #5 sysClk = ~sysClk;

  usart_frame_arb #(
    .NREQ(NREQ), .BPS_CNT(BPS_CNT), .FRAME_CYC(FRAME_CYC), .TRIG_HI(TRIG_HI)
  ) dut (
    .sys_clk(sysClk), .sys_rst(sysRst),
    .req_i(req), .req_adr_i(reqAdr), .req_mod_i(reqMod), .req_data_i(reqData),
    .ack_o(ack), .trig_o(trig), .Adress_o(adress), .Mod_SEL_o(modSel), .D_o(dOut),
    .busy_o(busy), .grant_id_o(grantId)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(rrPtr + k) % NREQ]) return (rrPtr + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic checkOutput();
    int d;
    bit inFrame;
    logic [NREQ-1:0] expAck;
    d = edgeNo - frameStart;
    inFrame = (d >= 0) && (d < BUSY_LEN);
    expAck = (inFrame && d == 0) ? (NREQ'(1) << mGrant) : '0;
    checkVal("ack", 32'(ack), 32'(expAck));
    checkVal("trig", 32'(trig), 32'(inFrame && d >= 1 && d <= TRIG_HI));
    checkVal("busy", 32'(busy), 32'(inFrame));
    checkVal("adr", 32'(adress), 32'(mAdr));
    checkVal("mod", 32'(modSel), 32'(mMod));
    checkVal("data", 32'(dOut), 32'(mData));
    checkVal("grant", 32'(grantId), 32'(mGrant));
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r);
    req = r;
  endtask

  task automatic setSlice(input int i, input logic [1:0] a, input logic [5:0] m, input logic [23:0] d);
    reqAdr[2*i +: 2]   = a;
    reqMod[6*i +: 6]   = m;
    reqData[24*i +: 24] = d;
  endtask

  // One clock: update the model at the edge, check the DUT just after it, then let requesters react.
  task automatic tick();
    int w;
    @(posedge sysClk);
    edgeNo++;
    if (edgeNo == nextSample) begin
      if (req != '0) begin
        w = pickWinner(req);
        frameStart = edgeNo;
        mGrant = 3'(w);
        mAdr  = reqAdr[2*w +: 2];
        mMod  = reqMod[6*w +: 6];
        mData = reqData[24*w +: 24];
        rrPtr = (w + 1) % NREQ;
        nextSample = edgeNo + PERIOD;
      end else begin
        nextSample = edgeNo + 1;
      end
    end
    #1;
    checkOutput();
    if (ack != '0) obsGrants.push_back(int'(grantId));
    if (trig && !prevTrig) trigEdges.push_back(edgeNo);
    prevTrig = trig;
    if (edgeNo == frameStart && dropOnAck[mGrant]) req[mGrant] = 1'b0;
    if (jitter) begin
      for (int i = 0; i < NREQ; i++)
        setSlice(i, 2'($urandom), 6'($urandom), 24'($urandom));
    end
  endtask

  task automatic runFor(input int n);
    repeat (n) tick();
  endtask

  // Expected order packed one nibble per grant, first grant in the low nibble.
  task automatic checkOrder(input string tag, input int count, input logic [31:0] packedExp);
    checkVal({tag, "_len"}, 32'(obsGrants.size()), 32'(count));
    for (int i = 0; i < count; i++) begin
      if (i < obsGrants.size()) checkVal(tag, 32'(obsGrants[i]), (packedExp >> (4*i)) & 32'hF);
    end
    obsGrants.delete();
  endtask

  // Called right after a tick; pulls reset low between clock edges and checks the async clear.
  task automatic resetPulse(input int lowCycles);
    #3;
    sysRst = 1'b0;
    #1;
    checkVal("rst_trig", 32'(trig), 32'h0);
    checkVal("rst_ack", 32'(ack), 32'h0);
    checkVal("rst_busy", 32'(busy), 32'h0);
    checkVal("rst_data", 32'(dOut), 32'h0);
    checkVal("rst_adr", 32'(adress), 32'h0);
    checkVal("rst_grant", 32'(grantId), 32'h0);
    repeat (lowCycles) begin
      @(posedge sysClk);
      edgeNo++;
    end
    #4;
    sysRst = 1'b1;
    frameStart = -100000;
    nextSample = edgeNo + 1;
    rrPtr = 0;
    mGrant = '0; mAdr = '0; mMod = '0; mData = '0;
    prevTrig = 1'b0;
    obsGrants.delete();
    trigEdges.delete();
  endtask

  task automatic waitAck(input string tag, input int limit, output int latency);
    bit seen;
    seen = 1'b0;
    latency = 0;
    while (!seen && latency < limit) begin
      tick();
      latency++;
      if (ack != '0) seen = 1'b1;
    end
    checkVal({tag, "_ack_seen"}, 32'(seen), 32'h1);
  endtask

  initial begin
    int lat, busyCnt, trigCnt;
    foreach (dropOnAck[i]) dropOnAck[i] = 1'b1;

    #1 sysRst = 1'b0;
    #1;
    checkVal("por_ack", 32'(ack), 32'h0);
    checkVal("por_trig", 32'(trig), 32'h0);
    checkVal("por_busy", 32'(busy), 32'h0);
    checkVal("por_data", 32'(dOut), 32'h0);
    checkVal("por_grant", 32'(grantId), 32'h0);
    repeat (3) begin
      @(posedge sysClk);
      edgeNo++;
    end
    #4 sysRst = 1'b1;
    nextSample = edgeNo + 1;
    runFor(3);

    $display("[TB] single request from requester 2");
    setSlice(2, 2'b11, 6'h2A, 24'hABCDEF);
    applyStimulus(4'b0100);
    waitAck("single", 10, lat);
    checkVal("single_latency", 32'(lat), 32'd1);
    checkVal("single_ack", 32'(ack), 32'h4);
    checkVal("single_adr", 32'(adress), 32'h3);
    checkVal("single_mod", 32'(modSel), 32'h2A);
    checkVal("single_data", 32'(dOut), 32'hABCDEF);
    busyCnt = int'(busy);
    trigCnt = 0;
    repeat (BUSY_LEN + 5) begin
      tick();
      busyCnt += int'(busy);
      trigCnt += int'(trig);
    end
    checkVal("single_busy_len", 32'(busyCnt), 32'd224);
    checkVal("single_trig_len", 32'(trigCnt), 32'd2);

    $display("[TB] four simultaneous requesters");
    resetPulse(2);
    applyStimulus(4'b1111);
    runFor(4*PERIOD + 5);
    checkOrder("order_all", 4, 32'h3210);
    checkVal("trig_edges", 32'(trigEdges.size()), 32'd4);
    for (int k = 0; k + 1 < trigEdges.size(); k++)
      checkVal("trig_spacing", 32'(trigEdges[k+1] - trigEdges[k]), 32'd225);
    applyStimulus(4'b0011);
    runFor(2*PERIOD + 5);
    checkOrder("order_wrap", 2, 32'h10);

    $display("[TB] late request raised during a frame");
    resetPulse(2);
    jitter = 1'b1;
    applyStimulus(4'b1001);
    runFor(60);
    req[1] = 1'b1;
    runFor(3*PERIOD);
`ifdef ARB_FIXED_PRIO_EN
    checkOrder("order_late", 3, 32'h310);
`else
    checkOrder("order_late", 3, 32'h310);
`endif
    jitter = 1'b0;

    $display("[TB] reset in the middle of a frame");
    applyStimulus(4'b0001);
    waitAck("midrst", 10, lat);
    runFor(53);
    resetPulse(5);
    applyStimulus(4'b0001);
    runFor(PERIOD + 2);
    checkOrder("order_after_rst", 1, 32'h0);

    $display("[TB] two requesters holding req");
    resetPulse(2);
    foreach (dropOnAck[i]) dropOnAck[i] = 1'b0;
    applyStimulus(4'b0101);
    runFor(4*PERIOD - 10);
`ifdef ARB_FIXED_PRIO_EN
    checkOrder("order_hold", 4, 32'h0000);
`else
    checkOrder("order_hold", 4, 32'h2020);
`endif
    applyStimulus(4'b0000);
    runFor(PERIOD);

`ifdef ARB_FIXED_PRIO_EN
    $display("[TB] fixed priority with requesters 1 and 3");
    obsGrants.delete();
    applyStimulus(4'b1010);
    runFor(2*PERIOD - 10);
    req[1] = 1'b0;
    runFor(PERIOD);
    checkOrder("order_fixed", 3, 32'h311);
    applyStimulus(4'b0000);
    runFor(PERIOD);
`endif

    $display("[TB] randomized requesters");
    jitter = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      foreach (dropOnAck[i]) dropOnAck[i] = 1'($urandom_range(0, 1));
      repeat (260) begin
        tick();
        if ($urandom_range(0, 19) == 0) req[$urandom_range(0, NREQ-1)] = 1'b1;
        if ($urandom_range(0, 99) == 0) req[$urandom_range(0, NREQ-1)] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
